bsg_nonsynth_mem_initiator_tester: RTL and testbench
====================================================

// Module: bsg_nonsynth_mem_initiator_tester
// PURPOSE
// - Nonsynth traffic initiator on the manycore link: writes num_words_p pattern words to one remote memory,
//   reads them all back, and checks every return packet. The requester-side counterpart to manycore memory
//   responders; sits at a testbench link port and reports pass/fail.
// PARAMETERS
// - data_width_p    32       link payload width (multiple of 8)
// - addr_width_p    28       manycore EPA width
// - x_cord_width_p  7        x coordinate width
// - y_cord_width_p  7        y coordinate width
// - num_words_p     256      words written then read; >=1, <=2**addr_width_p
// - base_addr_p     0        word EPA of first word
// - max_out_p       16       outstanding-request limit, 1..32
// - seed_p          32'h5A5A_0F0F  pattern seed
// PORTS
// - clk_i         in   1         clock
// - reset_i       in   1         reset, asynchronous, active-high
// - link_sif_i    in   link_sif  manycore link input
// - link_sif_o    out  link_sif  manycore link output
// - my_x_i        in   x_cord_w  own x coordinate (src_x_cord)
// - my_y_i        in   y_cord_w  own y coordinate (src_y_cord)
// - dest_x_i      in   x_cord_w  target x coordinate
// - dest_y_i      in   y_cord_w  target y coordinate
// - start_i       in   1         single-cycle start pulse
// - busy_o        out  1         run in progress
// - done_o        out  1         run finished, held until next start
// - error_o       out  1         sticky: at least one mismatch/protocol error
// - err_count_o   out  16        saturating error count
// BEHAVIOUR
// - Reset: state IDLE; busy_o=0, done_o=0, error_o=0, err_count_o=0, credits=max_out_p, in-flight table clear.
// - pattern(i) = (i*32'h9E37_79B1 ^ seed_p)[data_width_p-1:0]; addr(i) = base_addr_p+i.
// - FSM: IDLE -start_i-> WRITE -last store issued-> WDRAIN -credits==max_out_p-> READ -last load issued->
//   RDRAIN -credits==max_out_p-> DONE -start_i-> WRITE (counters/flags cleared; error_o clears on start).
// - Issue: packet_v=1 iff state WRITE/READ & credits>0; fires on packet_v & endpoint ready; index i++ on fire.
//   WRITE: op_v2=e_remote_sw, payload=pattern(i). READ: op_v2=e_remote_load, load_info all zero (word, int_wb).
//   reg_id = tag = issue count mod 32; table[tag] <= {valid=1, index i}.
// - Return (yumi same cycle, always accepted): look up table[reg_id]; clear valid; credits++.
//   Error (+1) if: entry invalid; WRITE-phase return type != e_return_credit; READ-phase type != e_return_int_wb;
//   load data != pattern(table index).
// - Issue and return in same cycle: credits unchanged; table write+clear on same tag (only when max_out_p=32
//   and tag wraps) -> write wins, old entry return still checked against pre-write contents.
// - credits==0: issue stalls, no packet_v. credits never exceed max_out_p; overflow return counted as error.
// - start_i while busy_o: ignored. busy_o=1 in WRITE..RDRAIN; done_o=1 in DONE only.
// - err_count_o saturates at 16'hFFFF; error_o = (err_count_o!=0).
// - Reset mid-run: immediate return to reset values; in-flight returns arriving after reset counted as
//   spurious errors only if a new run has started (IDLE drops returns silently).
// - Latency: first store one cycle after start_i if endpoint ready; no combinational link_sif_i->link_sif_o path.
// STRUCTURE
// - Sub-module: bsg_manycore_endpoint (fifo_els_p=4) for packet/return framing; return side uses yumi.
// - Shared package (bsg_manycore_pkg): packet/return typedefs, op_v2 and return pkt_type enums, load_info_s.
// - Local only: state enum, pattern function, 32-entry {valid,index} table (flops).
// TESTING
// - num_words_p=8, max_out_p=4, ideal memory responder -> 8 stores, 8 loads, done_o=1, err_count_o=0.
// - Responder corrupts load to word 3 (xor 1) -> err_count_o=1, error_o=1, done_o still 1.
// - Responder stalls returns 20 cycles -> exactly max_out_p=4 requests in flight, then no packet_v.
// - Inject return with unused reg_id 31 in READ -> err_count_o=1; credits stay <=max_out_p.
// - Assert reset_i mid-READ (word 5) -> all outputs 0 next edge; re-start completes clean, err_count_o=0.
// - Pulse start_i during WRITE -> ignored; run completes with exactly num_words_p stores.

Source files
------------

// File: rtl/bsg_nonsynth_mem_initiator_tester_pkg.sv
// Manycore link types shared by the memory initiator tester.
// Packet/return opcodes, load info and flat link layouts.
package bsg_nonsynth_mem_initiator_tester_pkg;

  localparam int reg_id_width_gp   = 5;
  localparam int op_width_gp       = 4;
  localparam int ret_type_width_gp = 2;
  localparam int table_els_gp      = 32;

  typedef enum logic [3:0] {
    e_remote_load    = 4'd0,
    e_remote_store   = 4'd1,
    e_remote_sw      = 4'd2,
    e_cache_op       = 4'd3,
    e_remote_amoswap = 4'd4,
    e_remote_amoadd  = 4'd5
  } bsg_manycore_packet_op_e;

  typedef enum logic [1:0] {
    e_return_credit   = 2'd0,
    e_return_int_wb   = 2'd1,
    e_return_float_wb = 2'd2,
    e_return_ifetch   = 2'd3
  } bsg_manycore_return_packet_type_e;

  typedef struct packed {
    logic       float_wb;
    logic       icache_fetch;
    logic       is_unsigned_op;
    logic       is_byte_op;
    logic       is_hex_op;
    logic [1:0] part_sel;
  } bsg_manycore_load_info_s;

  // request: {addr, op_v2, reg_id, payload,
  //           src_y, src_x, dest_y, dest_x}
  function automatic int packet_width(
    int addr_w, int data_w, int x_w, int y_w
  );
    return addr_w + op_width_gp + reg_id_width_gp
         + data_w + 2 * (x_w + y_w);
  endfunction

  // return: {pkt_type, data, reg_id, y_cord, x_cord}
  function automatic int return_width(
    int data_w, int x_w, int y_w
  );
    return ret_type_width_gp + data_w
         + reg_id_width_gp + x_w + y_w;
  endfunction

endpackage

// File: rtl/bsg_nonsynth_mem_initiator_tester_endpoint.sv
// Link endpoint: small request and return queues.
// link_out={fwd_v,fwd_pkt,rev_ready}; link_in={fwd_ready,rev_v,rev_pkt}.
module bsg_nonsynth_mem_initiator_tester_endpoint #(
  parameter int pkt_w_p    = 97,
  parameter int ret_w_p    = 53,
  parameter int fifo_els_p = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [ret_w_p+1:0] link_in,
  output logic [pkt_w_p+1:0] link_out,
  input  logic               out_v,
  input  logic [pkt_w_p-1:0] out_packet,
  output logic               out_ready,
  output logic               ret_v,
  output logic [ret_w_p-1:0] ret_packet,
  input  logic               ret_yumi
);

  localparam int ptr_w_lp = $clog2(fifo_els_p);
  localparam int cnt_w_lp = $clog2(fifo_els_p + 1);
  localparam logic [cnt_w_lp-1:0] full_lp =
    cnt_w_lp'(fifo_els_p);
  localparam logic [ptr_w_lp-1:0] last_lp =
    ptr_w_lp'(fifo_els_p - 1);

  function automatic logic [ptr_w_lp-1:0] bump(
    input logic [ptr_w_lp-1:0] p
  );
    return (p == last_lp) ? '0 : p + ptr_w_lp'(1);
  endfunction

  logic [pkt_w_p-1:0]  fwd_mem [fifo_els_p];
  logic [ptr_w_lp-1:0] fwd_wp, fwd_rp;
  logic [cnt_w_lp-1:0] fwd_cnt;
  logic [ret_w_p-1:0]  rev_mem [fifo_els_p];
  logic [ptr_w_lp-1:0] rev_wp, rev_rp;
  logic [cnt_w_lp-1:0] rev_cnt;

  logic fwd_ready, fwd_enq, fwd_deq;
  logic rev_in_v, rev_ready, rev_enq, rev_deq;

  assign fwd_ready = link_in[ret_w_p+1];
  assign rev_in_v  = link_in[ret_w_p];

  assign out_ready = (fwd_cnt != full_lp);
  assign fwd_enq   = out_v & out_ready;
  assign fwd_deq   = (fwd_cnt != '0) & fwd_ready;

  assign rev_ready = (rev_cnt != full_lp);
  assign rev_enq   = rev_in_v & rev_ready;
  assign ret_v     = (rev_cnt != '0);
  assign rev_deq   = ret_yumi & ret_v;

  assign ret_packet = rev_mem[rev_rp];
  assign link_out   = {fwd_cnt != '0,
                       fwd_mem[fwd_rp],
                       rev_ready};

  // request queue pointers and occupancy
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fwd_wp  <= '0;
      fwd_rp  <= '0;
      fwd_cnt <= '0;
    end else begin
      if (fwd_enq) fwd_wp <= bump(fwd_wp);
      if (fwd_deq) fwd_rp <= bump(fwd_rp);
      fwd_cnt <= fwd_cnt + cnt_w_lp'(fwd_enq)
                         - cnt_w_lp'(fwd_deq);
    end
  end

  // request queue storage
  always_ff @(posedge clk) begin
    if (fwd_enq) fwd_mem[fwd_wp] <= out_packet;
  end

  // return queue pointers and occupancy
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rev_wp  <= '0;
      rev_rp  <= '0;
      rev_cnt <= '0;
    end else begin
      if (rev_enq) rev_wp <= bump(rev_wp);
      if (rev_deq) rev_rp <= bump(rev_rp);
      rev_cnt <= rev_cnt + cnt_w_lp'(rev_enq)
                         - cnt_w_lp'(rev_deq);
    end
  end

  // return queue storage
  always_ff @(posedge clk) begin
    if (rev_enq) rev_mem[rev_wp] <= link_in[ret_w_p-1:0];
  end

endmodule

// File: rtl/bsg_nonsynth_mem_initiator_tester.sv
// Writes a pattern to one remote memory, reads it back
// and counts bad or unexpected return packets.
module bsg_nonsynth_mem_initiator_tester
  import bsg_nonsynth_mem_initiator_tester_pkg::*;
#(
  parameter int          data_width_p   = 32,
  parameter int          addr_width_p   = 28,
  parameter int          x_cord_width_p = 7,
  parameter int          y_cord_width_p = 7,
  parameter int          num_words_p    = 256,
  parameter int          base_addr_p    = 0,
  parameter int          max_out_p      = 16,
  parameter logic [31:0] seed_p         = 32'h5A5A_0F0F,
  localparam int pkt_w_lp = packet_width(addr_width_p,
    data_width_p, x_cord_width_p, y_cord_width_p),
  localparam int ret_w_lp = return_width(data_width_p,
    x_cord_width_p, y_cord_width_p)
) (
  input  logic                      clk_i,
  input  logic                      reset_i,
  input  logic [ret_w_lp+1:0]       link_sif_i,
  output logic [pkt_w_lp+1:0]       link_sif_o,
  input  logic [x_cord_width_p-1:0] my_x_i,
  input  logic [y_cord_width_p-1:0] my_y_i,
  input  logic [x_cord_width_p-1:0] dest_x_i,
  input  logic [y_cord_width_p-1:0] dest_y_i,
  input  logic                      start_i,
  output logic                      busy_o,
  output logic                      done_o,
  output logic                      error_o,
  output logic [15:0]               err_count_o
);

  typedef enum logic [2:0] {
    S_IDLE, S_WRITE, S_WDRAIN, S_READ, S_RDRAIN, S_DONE
  } state_e;

  localparam int idx_w_lp =
    (num_words_p > 1) ? $clog2(num_words_p) : 1;
  localparam int cred_w_lp = $clog2(max_out_p + 1);
  localparam int cord_w_lp = x_cord_width_p + y_cord_width_p;
  localparam logic [cred_w_lp-1:0] max_cred_lp =
    cred_w_lp'(max_out_p);
  localparam logic [idx_w_lp-1:0] last_idx_lp =
    idx_w_lp'(num_words_p - 1);

  function automatic logic [data_width_p-1:0] pattern(
    input logic [idx_w_lp-1:0] i
  );
    logic [31:0] p;
    p = (32'(i) * 32'h9E37_79B1) ^ seed_p;
    return data_width_p'(p);
  endfunction

  state_e state_r, state_n;
  logic [idx_w_lp-1:0]        idx_r;
  logic [cred_w_lp-1:0]       credits_r;
  logic [reg_id_width_gp-1:0] tag_r;
  logic [table_els_gp-1:0]    tbl_v_r;
  logic [idx_w_lp-1:0]        tbl_idx_r [table_els_gp];
  logic [15:0]                err_r;

  logic                out_v, out_ready;
  logic [pkt_w_lp-1:0] out_pkt;
  logic                ret_v, ret_yumi;
  logic [ret_w_lp-1:0] ret_pkt;

  bsg_nonsynth_mem_initiator_tester_endpoint #(
    .pkt_w_p   (pkt_w_lp),
    .ret_w_p   (ret_w_lp),
    .fifo_els_p(4)
  ) endpoint (
    .clk       (clk_i),
    .rst       (reset_i),
    .link_in   (link_sif_i),
    .link_out  (link_sif_o),
    .out_v     (out_v),
    .out_packet(out_pkt),
    .out_ready (out_ready),
    .ret_v     (ret_v),
    .ret_packet(ret_pkt),
    .ret_yumi  (ret_yumi)
  );

  logic issue_phase, read_phase, write_st, live;
  logic fire, last, start_ok;

  assign write_st    = (state_r == S_WRITE);
  assign issue_phase = write_st || (state_r == S_READ);
  assign read_phase  = (state_r == S_READ)
                    || (state_r == S_RDRAIN);
  assign live        = issue_phase || read_phase
                    || (state_r == S_WDRAIN);
  assign start_ok    = start_i && ((state_r == S_IDLE)
                    || (state_r == S_DONE));

  assign out_v = issue_phase && (credits_r != '0);
  assign fire  = out_v && out_ready;
  assign last  = (idx_r == last_idx_lp);

  bsg_manycore_load_info_s     load_info;
  logic [data_width_p-1:0]     payload;
  logic [op_width_gp-1:0]      op;
  logic [addr_width_p-1:0]     addr;

  assign load_info = '0;
  assign payload = write_st ? pattern(idx_r)
                            : data_width_p'(load_info);
  assign op   = write_st ? e_remote_sw : e_remote_load;
  assign addr = addr_width_p'(base_addr_p)
              + addr_width_p'(idx_r);
  assign out_pkt = {addr, op, tag_r, payload,
                    my_y_i, my_x_i, dest_y_i, dest_x_i};

  logic [ret_type_width_gp-1:0] ret_type, exp_type;
  logic [data_width_p-1:0]      ret_data;
  logic [reg_id_width_gp-1:0]   ret_id;
  logic [cord_w_lp-1:0]         ret_cords;
  logic                         unused_cords;
  logic hit_v, ret_hit, ret_credit, ret_err;
  logic [idx_w_lp-1:0]          hit_idx;

  assign {ret_type, ret_data, ret_id, ret_cords} = ret_pkt;
  assign unused_cords = ^ret_cords;

  // returns are always taken; outside a run they vanish
  assign ret_yumi   = ret_v;
  assign ret_hit    = ret_v && live;
  assign hit_v      = tbl_v_r[ret_id];
  assign hit_idx    = tbl_idx_r[ret_id];
  assign exp_type   = read_phase ? e_return_int_wb
                                 : e_return_credit;
  assign ret_credit = ret_hit && hit_v
                   && (credits_r != max_cred_lp);
  assign ret_err = ret_hit && (!hit_v
                || (credits_r == max_cred_lp)
                || (ret_type != exp_type)
                || (read_phase
                    && ret_data != pattern(hit_idx)));

  // state register
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) state_r <= S_IDLE;
    else         state_r <= state_n;
  end

  // phase sequencing
  always_comb begin
    state_n = state_r;
    unique case (state_r)
      S_IDLE, S_DONE:
        if (start_i) state_n = S_WRITE;
      S_WRITE:
        if (fire && last) state_n = S_WDRAIN;
      S_WDRAIN:
        if (credits_r == max_cred_lp) state_n = S_READ;
      S_READ:
        if (fire && last) state_n = S_RDRAIN;
      S_RDRAIN:
        if (credits_r == max_cred_lp) state_n = S_DONE;
      default: state_n = S_IDLE;
    endcase
  end

  // word index, tag and credit tracking
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      idx_r     <= '0;
      tag_r     <= '0;
      credits_r <= max_cred_lp;
    end else if (start_ok) begin
      idx_r     <= '0;
      tag_r     <= '0;
      credits_r <= max_cred_lp;
    end else begin
      if (fire) begin
        idx_r <= last ? '0 : idx_r + idx_w_lp'(1);
        tag_r <= tag_r + reg_id_width_gp'(1);
      end
      if (fire && !ret_credit)
        credits_r <= credits_r - cred_w_lp'(1);
      else if (!fire && ret_credit)
        credits_r <= credits_r + cred_w_lp'(1);
    end
  end

  // in-flight valid bits; a new issue beats a clear
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      tbl_v_r <= '0;
    end else if (start_ok) begin
      tbl_v_r <= '0;
    end else begin
      if (ret_hit) tbl_v_r[ret_id] <= 1'b0;
      if (fire)    tbl_v_r[tag_r]  <= 1'b1;
    end
  end

  // word index carried by each in-flight tag
  always_ff @(posedge clk_i) begin
    if (fire) tbl_idx_r[tag_r] <= idx_r;
  end

  // saturating error count, cleared by a new run
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i)       err_r <= '0;
    else if (start_ok) err_r <= '0;
    else if (ret_err && err_r != 16'hFFFF)
      err_r <= err_r + 16'd1;
  end

  assign busy_o      = live;
  assign done_o      = (state_r == S_DONE);
  assign err_count_o = err_r;
  assign error_o     = (err_r != 16'd0);

endmodule

// File: tb/tb_bsg_nonsynth_mem_initiator_tester.sv
// Bench: memory responder model on the link, runs
// clean, corrupted, stalled, spurious and reset cases.
module tb_bsg_nonsynth_mem_initiator_tester;
  import bsg_nonsynth_mem_initiator_tester_pkg::*;

  localparam int NW = 8;
  localparam int MO = 4;
  localparam int PW = packet_width(28, 32, 7, 7);
  localparam int RW = return_width(32, 7, 7);

  logic          clk = 1'b0;
  logic          rst;
  logic [RW+1:0] link_i;
  logic [PW+1:0] link_o;
  logic [6:0]    my_x = 7'd3, my_y = 7'd2;
  logic [6:0]    dx = 7'd5, dy = 7'd1;
  logic          start;
  logic          busy, done, error;
  logic [15:0]   err_count;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  bsg_nonsynth_mem_initiator_tester #(
    .num_words_p(NW),
    .max_out_p  (MO)
  ) dut (
    .clk_i      (clk),
    .reset_i    (rst),
    .link_sif_i (link_i),
    .link_sif_o (link_o),
    .my_x_i     (my_x),
    .my_y_i     (my_y),
    .dest_x_i   (dx),
    .dest_y_i   (dy),
    .start_i    (start),
    .busy_o     (busy),
    .done_o     (done),
    .error_o    (error),
    .err_count_o(err_count)
  );

  logic          fwd_ready, rev_v;
  logic [RW-1:0] rpkt;
  logic          fwd_v, rev_ready;
  logic [PW-1:0] fpkt;

  assign link_i    = {fwd_ready, rev_v, rpkt};
  assign fwd_v     = link_o[PW+1];
  assign fpkt      = link_o[PW:1];
  assign rev_ready = link_o[0];

  typedef struct {
    int            due;
    logic [RW-1:0] pkt;
  } ret_t;

  ret_t        q[$];
  logic [31:0] mem [256];
  int cyc = 0;
  int ready_pct = 75;
  int corrupt_word = -1;
  bit stall_ret = 0;
  bit inj_pending = 0;
  int n_st, n_ld, bad_pkt, inflight, max_inflight;

  function automatic logic [31:0] pat(input int i);
    logic [31:0] ii;
    ii = i;
    return (ii * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  // memory responder: acts on negedge, handshakes at posedge
  initial begin
    ret_t        r;
    logic [27:0] a;
    logic [3:0]  op;
    logic [4:0]  rid;
    logic [31:0] pay, d;
    logic [6:0]  sy, sx, ddy, ddx;
    int          i;
    fwd_ready = 1'b0;
    rev_v = 1'b0;
    rpkt = '0;
    inflight = 0;
    max_inflight = 0;
    forever begin
      @(negedge clk);
      cyc++;
      rev_v = 1'b0;
      if (rev_ready && !stall_ret) begin
        if (inj_pending) begin
          rev_v = 1'b1;
          rpkt = {2'd1, 32'd0, 5'd31, my_y, my_x};
          inj_pending = 0;
        end else if (q.size() != 0 && q[0].due <= cyc) begin
          r = q.pop_front();
          rev_v = 1'b1;
          rpkt = r.pkt;
          inflight--;
        end
      end
      fwd_ready = ($urandom_range(99) < ready_pct);
      if (fwd_ready && fwd_v && !rst) begin
        {a, op, rid, pay, sy, sx, ddy, ddx} = fpkt;
        i = int'(a);
        if (sx != my_x || sy != my_y ||
            ddx != dx || ddy != dy) bad_pkt++;
        r.due = cyc + int'($urandom_range(3));
        if (op == 4'd2) begin
          if (i != n_st || pay != pat(i)) bad_pkt++;
          mem[a[7:0]] = pay;
          n_st++;
          r.pkt = {2'd0, 32'd0, rid, sy, sx};
        end else if (op == 4'd0) begin
          if (i != n_ld || pay != 32'd0) bad_pkt++;
          d = mem[a[7:0]];
          if (i == corrupt_word) d = d ^ 32'd1;
          n_ld++;
          r.pkt = {2'd1, d, rid, sy, sx};
        end else begin
          bad_pkt++;
          r.pkt = {2'd0, 32'd0, rid, sy, sx};
        end
        q.push_back(r);
        inflight++;
        if (inflight > max_inflight) max_inflight = inflight;
      end
    end
  end

  task automatic pulse_start;
    @(posedge clk);
    #2;
    n_st = 0;
    n_ld = 0;
    bad_pkt = 0;
    start = 1'b1;
    @(posedge clk);
    #2 start = 1'b0;
  endtask

  task automatic wait_done(output bit to);
    to = 1;
    for (int k = 0; k < 3000; k++) begin
      @(posedge clk);
      #1;
      if (done) begin
        to = 0;
        break;
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (busy !== 1'b0) begin
      bad++; $display("FAIL rst_busy got=%0b want=0", busy);
    end
    total++;
    if (done !== 1'b0) begin
      bad++; $display("FAIL rst_done got=%0b want=0", done);
    end
    total++;
    if (error !== 1'b0) begin
      bad++; $display("FAIL rst_error got=%0b want=0", error);
    end
    total++;
    if (err_count !== 16'd0) begin
      bad++; $display("FAIL rst_errcnt got=%0d want=0", err_count);
    end
    #1 rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if (fwd_v !== 1'b0) begin
      bad++; $display("FAIL idle_fwd_v got=%0b want=0", fwd_v);
    end
  endtask

  task automatic test_clean;
    bit to;
    ready_pct = 75;
    pulse_start();
    @(posedge clk);
    #1;
    total++;
    if (fwd_v !== 1'b1 || busy !== 1'b1) begin
      bad++;
      $display("FAIL first_store v=%0b busy=%0b want=1/1",
               fwd_v, busy);
    end
    wait_done(to);
    total++;
    if (to) begin
      bad++; $display("FAIL clean_timeout done=%0b want=1", done);
    end
    total++;
    if (busy !== 1'b0) begin
      bad++; $display("FAIL clean_busy got=%0b want=0", busy);
    end
    total++;
    if (err_count !== 16'd0 || error !== 1'b0) begin
      bad++;
      $display("FAIL clean_err got=%0d/%0b want=0/0",
               err_count, error);
    end
    total++;
    if (n_st != NW || n_ld != NW) begin
      bad++;
      $display("FAIL clean_counts st=%0d ld=%0d want=%0d",
               n_st, n_ld, NW);
    end
    total++;
    if (bad_pkt != 0) begin
      bad++; $display("FAIL clean_pkts got=%0d want=0", bad_pkt);
    end
  endtask

  task automatic test_corrupt;
    bit to;
    corrupt_word = 3;
    pulse_start();
    wait_done(to);
    corrupt_word = -1;
    total++;
    if (to || done !== 1'b1) begin
      bad++; $display("FAIL corrupt_done got=%0b want=1", done);
    end
    total++;
    if (err_count !== 16'd1) begin
      bad++;
      $display("FAIL corrupt_errcnt got=%0d want=1", err_count);
    end
    total++;
    if (error !== 1'b1) begin
      bad++; $display("FAIL corrupt_error got=%0b want=1", error);
    end
  endtask

  task automatic test_stall;
    bit to;
    int late_v;
    late_v = 0;
    ready_pct = 100;
    stall_ret = 1;
    pulse_start();
    for (int k = 0; k < 20; k++) begin
      @(posedge clk);
      #1;
      if (k >= 10 && fwd_v) late_v++;
    end
    total++;
    if (inflight != MO || n_st != MO) begin
      bad++;
      $display("FAIL stall_inflight got=%0d st=%0d want=%0d",
               inflight, n_st, MO);
    end
    total++;
    if (late_v != 0) begin
      bad++; $display("FAIL stall_pkt_v got=%0d want=0", late_v);
    end
    #1;
    stall_ret = 0;
    ready_pct = 75;
    wait_done(to);
    total++;
    if (to || err_count !== 16'd0 || n_st != NW) begin
      bad++;
      $display("FAIL stall_finish err=%0d st=%0d want=0/%0d",
               err_count, n_st, NW);
    end
  endtask

  task automatic test_spurious;
    bit to;
    to = 1;
    pulse_start();
    for (int k = 0; k < 500; k++) begin
      @(posedge clk);
      #2;
      if (n_ld >= 1) begin
        to = 0;
        break;
      end
    end
    inj_pending = 1;
    total++;
    if (to) begin
      bad++; $display("FAIL spur_read_wait ld=%0d want>=1", n_ld);
    end
    wait_done(to);
    total++;
    if (to || err_count !== 16'd1) begin
      bad++;
      $display("FAIL spur_errcnt got=%0d want=1", err_count);
    end
    total++;
    if (max_inflight > MO || n_ld != NW) begin
      bad++;
      $display("FAIL spur_credit max=%0d ld=%0d want<=%0d/%0d",
               max_inflight, n_ld, MO, NW);
    end
  endtask

  task automatic test_reset_mid;
    bit to;
    to = 1;
    pulse_start();
    for (int k = 0; k < 500; k++) begin
      @(posedge clk);
      #2;
      if (n_ld >= 6) begin
        to = 0;
        break;
      end
    end
    total++;
    if (to) begin
      bad++; $display("FAIL mid_wait ld=%0d want>=6", n_ld);
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    total++;
    if ({busy, done, error, fwd_v} !== 4'b0 ||
        err_count !== 16'd0) begin
      bad++;
      $display("FAIL mid_reset_out got=%b/%0d want=0000/0",
               {busy, done, error, fwd_v}, err_count);
    end
    #1 rst = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    total++;
    if (busy !== 1'b0 || err_count !== 16'd0 || inflight != 0) begin
      bad++;
      $display("FAIL mid_idle_drop busy=%0b err=%0d fl=%0d want=0",
               busy, err_count, inflight);
    end
    pulse_start();
    wait_done(to);
    total++;
    if (to || err_count !== 16'd0 ||
        n_st != NW || n_ld != NW || bad_pkt != 0) begin
      bad++;
      $display("FAIL mid_rerun err=%0d st=%0d ld=%0d bp=%0d",
               err_count, n_st, n_ld, bad_pkt);
    end
  endtask

  task automatic test_start_in_write;
    bit to;
    pulse_start();
    @(posedge clk);
    #2 start = 1'b1;
    @(posedge clk);
    #2 start = 1'b0;
    wait_done(to);
    total++;
    if (to || n_st != NW || n_ld != NW) begin
      bad++;
      $display("FAIL restart_counts st=%0d ld=%0d want=%0d",
               n_st, n_ld, NW);
    end
    total++;
    if (err_count !== 16'd0 || bad_pkt != 0) begin
      bad++;
      $display("FAIL restart_err got=%0d bp=%0d want=0",
               err_count, bad_pkt);
    end
  endtask

  initial begin
    test_reset();
    test_clean();
    test_corrupt();
    test_stall();
    test_spurious();
    test_reset_mid();
    test_start_in_write();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
